// File: rtl/q_mac_pkg.sv
// Shared constants and FSM state type for the Q = X*T + N stream MAC.
package q_mac_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;
endpackage

// File: rtl/q_mac_stream_slot.sv
// Single-entry valid/ready holding register: captures one beat, then stalls
// until cleared, so repeated valid cycles never overwrite the held operand.
module stream_slot #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic         o_full,
  output logic [W-1:0] o_data
);
  logic         r_full;
  logic [W-1:0] r_data;

  assign o_ready = !i_rst && i_en && !r_full;
  assign o_full  = r_full;
  assign o_data  = r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_clr) begin
      r_full <= 1'b0;
    end else if (i_valid && o_ready) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end
  end
endmodule

// File: rtl/q_mac_top.sv
// Stream MAC: holds one X and one T, emits Q = X*T + N (N is a sticky offset).
// Build option: Q_SATURATE_EN clamps overflowing results to all ones.
module q_mac_top #(
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] N,
  input  logic              N_valid,
  output logic              N_ready,
  input  logic [DATA_W-1:0] X,
  input  logic              X_valid,
  output logic              X_ready,
  input  logic [DATA_W-1:0] T,
  input  logic              T_valid,
  output logic              T_ready,
  output logic [DATA_W-1:0] Q,
  output logic              Q_valid,
  input  logic              Q_ready
);
  import q_mac_pkg::*;

  state_t            r_state, w_state_nxt;
  logic              w_collect, w_clr;
  logic              w_x_full, w_t_full;
  logic [DATA_W-1:0] w_x, w_t, w_res;
  logic [DATA_W-1:0] r_n, r_q;
  logic              r_q_valid;

  assign w_collect = (r_state == COLLECT);
  assign w_clr     = (r_state == OUTPUT) && Q_ready;
  assign N_ready   = !aresetn;
  assign Q         = r_q;
  assign Q_valid   = r_q_valid;

  stream_slot #(.W(DATA_W)) u_x_slot (
    .i_clk(aclk), .i_rst(aresetn), .i_en(w_collect), .i_clr(w_clr),
    .i_data(X), .i_valid(X_valid), .o_ready(X_ready), .o_full(w_x_full), .o_data(w_x)
  );

  stream_slot #(.W(DATA_W)) u_t_slot (
    .i_clk(aclk), .i_rst(aresetn), .i_en(w_collect), .i_clr(w_clr),
    .i_data(T), .i_valid(T_valid), .o_ready(T_ready), .o_full(w_t_full), .o_data(w_t)
  );

`ifdef Q_SATURATE_EN
  // Full-width sum cannot overflow: (2^W-1)^2 + (2^W-1) < 2^(2W+1).
  logic [2*DATA_W:0] w_sum;
  assign w_sum = {{(DATA_W+1){1'b0}}, w_x} * {{(DATA_W+1){1'b0}}, w_t}
               + {{(DATA_W+1){1'b0}}, r_n};
  assign w_res = (|w_sum[2*DATA_W:DATA_W]) ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
`else
  assign w_res = w_x * w_t + r_n;
`endif

  always_ff @(posedge aclk) begin
    if (aresetn) r_state <= COLLECT;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      COLLECT: if (w_x_full && w_t_full) w_state_nxt = COMPUTE;
      COMPUTE: w_state_nxt = OUTPUT;
      OUTPUT:  if (Q_ready) w_state_nxt = COLLECT;
      default: w_state_nxt = COLLECT;
    endcase
  end

  // N is sampled by COMPUTE before a same-edge N transfer lands.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      r_n       <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else begin
      if (N_valid && N_ready) r_n <= N;
      if (r_state == COMPUTE) begin
        r_q       <= w_res;
        r_q_valid <= 1'b1;
      end else if (w_clr) begin
        r_q_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_q_mac_top.sv
// Directed + randomized bench for q_mac_top against an arithmetic reference model.
module tb_q_mac_top;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] N, X, T;
  logic        N_valid, X_valid, T_valid, Q_ready;
  logic        N_ready, X_ready, T_ready, Q_valid;
  logic [31:0] Q;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_n = '0;

  always #5 aclk = ~aclk;

  q_mac_top #(.DATA_W(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .N(N), .N_valid(N_valid), .N_ready(N_ready),
    .X(X), .X_valid(X_valid), .X_ready(X_ready),
    .T(T), .T_valid(T_valid), .T_ready(T_ready),
    .Q(Q), .Q_valid(Q_valid), .Q_ready(Q_ready)
  );

  function automatic logic [31:0] q_model(input logic [31:0] x, input logic [31:0] t,
                                          input logic [31:0] n);
    logic [64:0] f;
    f = 65'(x) * 65'(t) + 65'(n);
`ifdef Q_SATURATE_EN
    if (f > 65'h0_FFFF_FFFF) return 32'hFFFF_FFFF;
`endif
    return f[31:0];
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_n(input logic [31:0] v);
    N = v;
    N_valid = 1'b1;
    chk("n_ready", 32'(N_ready), 32'd1);
    tick();
    N_valid = 1'b0;
    m_n = v;
  endtask

  // mode 0: X and T together, 1: X first, 2: T first
  task automatic send_pair(input logic [31:0] x, input logic [31:0] t, input int mode);
    bit xd, td, xs, ts;
    int n;
    xd = 0; td = 0; n = 0;
    X = x; T = t;
    while (!(xd && td) && n < 50) begin
      X_valid = !xd && (mode != 2 || td);
      T_valid = !td && (mode != 1 || xd);
      xs = X_valid && X_ready;
      ts = T_valid && T_ready;
      tick();
      if (xs) xd = 1;
      if (ts) td = 1;
      n++;
    end
    X_valid = 1'b0;
    T_valid = 1'b0;
    chk("pair_accepted", 32'(xd && td), 32'd1);
  endtask

  task automatic wait_q();
    int n;
    n = 0;
    while (!Q_valid && n < 20) begin
      tick();
      n++;
    end
    chk("q_valid_arrives", 32'(Q_valid), 32'd1);
  endtask

  task automatic handshake(input string tag);
    Q_ready = 1'b1;
    tick();
    Q_ready = 1'b0;
    chk(tag, 32'(Q_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] x, t, q_hold;
    int mode;

    aresetn = 1'b1;
    N = '0; X = '0; T = '0;
    N_valid = 0; X_valid = 0; T_valid = 0; Q_ready = 0;

    // reset window
    repeat (10) tick();
    chk("rst_x_ready", 32'(X_ready), 32'd0);
    chk("rst_n_ready", 32'(N_ready), 32'd0);
    aresetn = 1'b0;
    tick();
    chk("post_rst_x_ready", 32'(X_ready), 32'd1);
    chk("post_rst_t_ready", 32'(T_ready), 32'd1);
    chk("post_rst_n_ready", 32'(N_ready), 32'd1);
    chk("post_rst_q_valid", 32'(Q_valid), 32'd0);
    chk("post_rst_q", Q, 32'd0);

    // X then T, Q_ready high early; check two-edge latency
    Q_ready = 1'b1;
    send_pair(32'd1, 32'd2, 1);
    chk("lat_edge0", 32'(Q_valid), 32'd0);
    tick();
    chk("lat_edge1", 32'(Q_valid), 32'd0);
    tick();
    chk("lat_edge2", 32'(Q_valid), 32'd1);
    chk("q_1x2", Q, q_model(32'd1, 32'd2, m_n));
    tick();
    Q_ready = 1'b0;
    chk("hs_clears_valid", 32'(Q_valid), 32'd0);
    chk("q_held_after_hs", Q, 32'd2);
    chk("x_ready_back", 32'(X_ready), 32'd1);
    chk("t_ready_back", 32'(T_ready), 32'd1);

    // X offered while a result is pending
    send_pair(32'd7, 32'd3, 2);
    wait_q();
    chk("q_7x3", Q, q_model(32'd7, 32'd3, m_n));
    X = 32'd2;
    X_valid = 1'b1;
    repeat (3) begin
      chk("x_blocked_pending", 32'(X_ready), 32'd0);
      tick();
    end
    handshake("hs_7x3");
    chk("x_ready_after_hs", 32'(X_ready), 32'd1);
    tick();
    X_valid = 1'b0;
    chk("x_no_double", 32'(X_ready), 32'd0);
    T = 32'd4;
    T_valid = 1'b1;
    chk("t_ready_single", 32'(T_ready), 32'd1);
    tick();
    T_valid = 1'b0;
    wait_q();
    chk("q_2x4", Q, q_model(32'd2, 32'd4, m_n));
    handshake("hs_2x4");

    // N persistence
    send_n(32'd5);
    send_pair(32'd3, 32'd4, 0);
    wait_q();
    chk("q_3x4p5", Q, q_model(32'd3, 32'd4, m_n));
    handshake("hs_3x4p5");
    send_pair(32'd1, 32'd1, 0);
    wait_q();
    chk("q_1x1p5", Q, q_model(32'd1, 32'd1, m_n));
    handshake("hs_1x1p5");

    // overflow boundary
    send_n(32'd0);
    send_pair(32'hFFFF_FFFF, 32'd2, 1);
    wait_q();
`ifdef Q_SATURATE_EN
    chk("q_ovf", Q, 32'hFFFF_FFFF);
`else
    chk("q_ovf", Q, 32'hFFFF_FFFE);
`endif
    chk("q_ovf_model", Q, q_model(32'hFFFF_FFFF, 32'd2, m_n));
    handshake("hs_ovf");

    // N transfer on the COMPUTE edge uses the old offset
    send_pair(32'd2, 32'd3, 0);
    tick();
    N = 32'd100;
    N_valid = 1'b1;
    tick();
    N_valid = 1'b0;
    chk("q_old_n_valid", 32'(Q_valid), 32'd1);
    chk("q_old_n", Q, q_model(32'd2, 32'd3, m_n));
    m_n = 32'd100;
    handshake("hs_old_n");
    send_pair(32'd1, 32'd1, 2);
    wait_q();
    chk("q_new_n", Q, q_model(32'd1, 32'd1, m_n));
    handshake("hs_new_n");

    // stall, then reset mid-wait
    send_pair(32'd9, 32'd9, 0);
    wait_q();
    q_hold = q_model(32'd9, 32'd9, m_n);
    repeat (10) begin
      chk("q_stable", Q, q_hold);
      chk("q_valid_stable", 32'(Q_valid), 32'd1);
      tick();
    end
    aresetn = 1'b1;
    tick();
    chk("rst_mid_q_valid", 32'(Q_valid), 32'd0);
    chk("rst_mid_t_ready", 32'(T_ready), 32'd0);
    aresetn = 1'b0;
    m_n = '0;
    repeat (5) tick();
    chk("rst_discard_q_valid", 32'(Q_valid), 32'd0);
    chk("rst_discard_x_ready", 32'(X_ready), 32'd1);
    send_pair(32'd2, 32'd2, 0);
    wait_q();
    chk("q_after_rst_n_cleared", Q, q_model(32'd2, 32'd2, m_n));
    handshake("hs_after_rst");

    // randomized operands, offsets and arrival orders
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) send_n($urandom);
      case ($urandom_range(0, 3))
        0:       x = 32'd0;
        1:       x = 32'hFFFF_FFFF;
        default: x = $urandom;
      endcase
      t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      mode = $urandom_range(0, 2);
      Q_ready = 1'($urandom_range(0, 1));
      send_pair(x, t, mode);
      wait_q();
      chk("q_rand", Q, q_model(x, t, m_n));
      if (!Q_ready) repeat ($urandom_range(0, 3)) tick();
      handshake("hs_rand");
      chk("q_rand_hold", Q, q_model(x, t, m_n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/q_mac_top.md
Name: q_mac_top

Overview:
- Stream arithmetic block with three 32-bit AXI-Stream-style input channels (N, X, T) and one output channel (Q).
- Collects one X and one T operand and computes Q = X*T + N, where N is a persistent offset register updated through its own channel.
- Sits as the top-level compute block behind the stream testbench and drivers; integer arithmetic only.

Parameters:
- DATA_W, 32, width of N, X, T and Q.

Ports:
- aclk  in  1  clock; all state changes on rising edge.
- aresetn  in  1  reset. Synchronous, active-high (asserted = 1), despite the name.
- N  in  DATA_W  offset value.
- N_valid  in  1  N channel valid.
- N_ready  out  1  N channel ready.
- X  in  DATA_W  operand X.
- X_valid  in  1  X channel valid.
- X_ready  out  1  X channel ready.
- T  in  DATA_W  operand T.
- T_valid  in  1  T channel valid.
- T_ready  out  1  T channel ready.
- Q  out  DATA_W  result.
- Q_valid  out  1  result valid.
- Q_ready  in  1  downstream ready.

Behaviour:
- Transfer rule: a transfer occurs on a rising edge where valid && ready.
- Reset (aresetn=1 at edge):
  - Clears x_full, t_full, n_reg=0, Q=0, Q_valid=0, state=COLLECT.
  - All ready outputs are 0 while aresetn=1.
- Operand holding:
  - X_ready = !rst && state==COLLECT && !x_full. An X transfer loads x_reg and sets x_full.
  - T_ready behaves identically with t_reg/t_full.
  - X and T may arrive in either order, or in the same cycle.
  - Once full, the channel's ready drops. Extra valid cycles are ignored (no double capture).
- N channel:
  - N_ready = !rst (always accepting). A transfer loads n_reg.
  - n_reg persists across results. It is never consumed and defaults to 0.
- States:
  - COLLECT -> COMPUTE when x_full && t_full, including when both are set on the same edge.
  - COMPUTE (1 cycle): Q <= (x_reg*t_reg + n_reg)[DATA_W-1:0], unsigned, wrap-around. Q_valid <= 1. Go to OUTPUT.
  - OUTPUT: Q and Q_valid held stable until Q_ready=1 at an edge. That edge clears Q_valid, x_full and t_full, and returns to COLLECT.
- Latency: Q_valid rises 2 edges after the edge that captures the last of X/T. Q_ready may already be high before Q_valid rises.
- Simultaneous N transfer and COMPUTE: COMPUTE uses the old n_reg; the new value applies to the next result.
- Q keeps its last value after the handshake. Only Q_valid drops.
- X or T presented during COMPUTE/OUTPUT: ready stays 0; the source waits.
- Reset mid-operation: aborts immediately, no partial output. Q_valid=0 on the next cycle.

Optional Feature:
- Macro Q_SATURATE_EN.
- Defined: X*T + N is computed at full 2*DATA_W+1 width. If it exceeds 2^DATA_W-1, Q = all ones.
- Undefined: low DATA_W bits only (wrap).

Decomposition:
- Package q_mac_pkg: DATA_W constant; state enum typedef {COLLECT, COMPUTE, OUTPUT}.
- One natural sub-module: stream_slot (valid/ready holding register with a full flag), instantiated for X and T.

Test Plan:
- Reset held 100 ns, then released: all readies 1 on the next cycle; Q_valid=0, Q=0.
- X=1, then T=2, N never sent, Q_ready raised early: Q_valid=1 with Q=2. One Q_ready handshake clears Q_valid; X_ready and T_ready return to 1.
- X=2 offered while the previous Q is pending: X_ready stays 0 until the Q handshake. Then X=2 and T=4 give Q=8.
- N=5 first, then X=3 and T=4 in the same cycle: Q=17. A second X=1, T=1 pair gives Q=6 (N persists).
- X=0xFFFF_FFFF, T=2, N=0: Q=0xFFFF_FFFE without Q_SATURATE_EN; Q=0xFFFF_FFFF with it.
- Q_ready held 0 for 10 cycles after Q_valid: Q stays stable. Reset asserted mid-wait: Q_valid=0 next cycle, and the operands are discarded.
